// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//
// Registered execute stage for the single-cycle MIPS datapath. Combines
// the ALU control decoder, a WIDTH-bit ALU with zero/overflow flags, and
// the two PC adders (PC+4 and branch target). Every output is a register
// that is loaded one clock after valid_in is seen high. When valid_in is
// low, the outputs hold their values and only valid_out drops.
//
// Ports:
//   Clk           in   rising-edge clock
//   Rst_n         in   synchronous active-low reset (dominates valid_in)
//   valid_in      in   inputs valid this cycle
//   alu_op [2:0]  in   operation class from the control unit
//   funct  [5:0]  in   instruction[5:0]
//   src_a         in   ALU operand A
//   src_b         in   ALU operand B (already muxed reg2/immediate)
//   pc            in   current PC
//   imm   [15:0]  in   instruction[15:0]
//   valid_out     out  registered valid_in
//   alu_ctrl[2:0] out  registered decoded ALU control
//   result        out  registered ALU result
//   zero          out  registered (result == 0)
//   overflow      out  registered signed overflow (ADD/SUB only)
//   pc_plus4      out  registered pc + 4
//   branch_target out  registered pc + 4 + (sext(imm) << 2)
// ---------------------------------------------------------------------------
module alu_exec_stage #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             valid_in,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [WIDTH-1:0] pc,
   input  logic [15:0]      imm,
   output logic             valid_out,
   output logic [2:0]       alu_ctrl,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target
);

   // ALU control encodings
   localparam logic [2:0] CTRL_AND = 3'b000;
   localparam logic [2:0] CTRL_OR  = 3'b001;
   localparam logic [2:0] CTRL_ADD = 3'b010;
   localparam logic [2:0] CTRL_NOR = 3'b100;
   localparam logic [2:0] CTRL_SUB = 3'b110;
   localparam logic [2:0] CTRL_SLT = 3'b111;

   // -----------------------------------------------------------------------
   // ALU control decode
   // -----------------------------------------------------------------------
   logic [2:0] alu_ctrl_next;

   always_comb begin
      alu_ctrl_next = CTRL_ADD;
      case (alu_op)
         3'b000:  alu_ctrl_next = CTRL_ADD;
         3'b001:  alu_ctrl_next = CTRL_SUB;
         3'b011:  alu_ctrl_next = CTRL_AND;
         3'b100:  alu_ctrl_next = CTRL_OR;
         3'b101:  alu_ctrl_next = CTRL_SLT;
         3'b010: begin
            case (funct)
               6'h20, 6'h21: alu_ctrl_next = CTRL_ADD;
               6'h22, 6'h23: alu_ctrl_next = CTRL_SUB;
               6'h24:        alu_ctrl_next = CTRL_AND;
               6'h25:        alu_ctrl_next = CTRL_OR;
               6'h27:        alu_ctrl_next = CTRL_NOR;
               6'h2A:        alu_ctrl_next = CTRL_SLT;
               default:      alu_ctrl_next = CTRL_ADD;
            endcase
         end
         default: alu_ctrl_next = CTRL_ADD;
      endcase
   end

   // -----------------------------------------------------------------------
   // ALU datapath
   // -----------------------------------------------------------------------
   logic [WIDTH-1:0] and_bits;
   logic [WIDTH-1:0] or_bits;
   logic [WIDTH-1:0] nor_bits;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             slt_bit;
   logic             add_ovf;
   logic             sub_ovf;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_logic_bits
         assign and_bits[gi] = src_a[gi] & src_b[gi];
         assign or_bits[gi]  = src_a[gi] | src_b[gi];
         assign nor_bits[gi] = ~(src_a[gi] | src_b[gi]);
      end
   endgenerate

   assign sum     = src_a + src_b;
   assign diff    = src_a - src_b;
   assign slt_bit = $signed(src_a) < $signed(src_b);

   // Same-sign operands whose sum flips sign overflowed; for subtraction,
   // opposite-sign operands whose difference differs in sign from a.
   assign add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                    (sum[WIDTH-1]   != src_a[WIDTH-1]);
   assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                    (diff[WIDTH-1]  != src_a[WIDTH-1]);

   logic [WIDTH-1:0] result_next;
   logic             overflow_next;

   always_comb begin
      result_next   = '0;
      overflow_next = 1'b0;
      case (alu_ctrl_next)
         CTRL_AND: result_next = and_bits;
         CTRL_OR:  result_next = or_bits;
         CTRL_NOR: result_next = nor_bits;
         CTRL_ADD: begin
            result_next   = sum;
            overflow_next = add_ovf;
         end
         CTRL_SUB: begin
            result_next   = diff;
            overflow_next = sub_ovf;
         end
         CTRL_SLT: result_next = {{(WIDTH-1){1'b0}}, slt_bit};
         default:  result_next = '0;
      endcase
   end

   // -----------------------------------------------------------------------
   // PC adders
   // -----------------------------------------------------------------------
   logic [WIDTH-1:0] pc_plus4_next;
   logic [WIDTH-1:0] branch_offset;
   logic [WIDTH-1:0] branch_target_next;

   assign pc_plus4_next      = pc + WIDTH'(4);
   assign branch_offset      = {{(WIDTH-18){imm[15]}}, imm, 2'b00};
   assign branch_target_next = pc_plus4_next + branch_offset;

   // -----------------------------------------------------------------------
   // Output registers
   // -----------------------------------------------------------------------
   logic             valid_reg;
   logic [2:0]       alu_ctrl_reg;
   logic [WIDTH-1:0] result_reg;
   logic             zero_reg;
   logic             overflow_reg;
   logic [WIDTH-1:0] pc_plus4_reg;
   logic [WIDTH-1:0] branch_target_reg;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         valid_reg         <= 1'b0;
         alu_ctrl_reg      <= '0;
         result_reg        <= '0;
         zero_reg          <= 1'b0;
         overflow_reg      <= 1'b0;
         pc_plus4_reg      <= '0;
         branch_target_reg <= '0;
      end else if (valid_in) begin
         valid_reg         <= 1'b1;
         alu_ctrl_reg      <= alu_ctrl_next;
         result_reg        <= result_next;
         zero_reg          <= (result_next == '0);
         overflow_reg      <= overflow_next;
         pc_plus4_reg      <= pc_plus4_next;
         branch_target_reg <= branch_target_next;
      end else begin
         // Idle cycle: data outputs hold, only the valid strobe drops.
         valid_reg         <= 1'b0;
      end
   end

   assign valid_out     = valid_reg;
   assign alu_ctrl      = alu_ctrl_reg;
   assign result        = result_reg;
   assign zero          = zero_reg;
   assign overflow      = overflow_reg;
   assign pc_plus4      = pc_plus4_reg;
   assign branch_target = branch_target_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Directed, table-driven bench for alu_exec_stage. Each table row carries
// the inputs and the hand-computed expected registered outputs. Separate
// sequences cover reset, the reset/valid interaction and the hold
// behaviour when valid_in is low.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

   logic        Clk;
   logic        Rst_n;
   logic        valid_in;
   logic [2:0]  alu_op;
   logic [5:0]  funct;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] pc;
   logic [15:0] imm;
   logic        valid_out;
   logic [2:0]  alu_ctrl;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;

   int err_cnt   = 0;
   int check_cnt = 0;

   alu_exec_stage #(.WIDTH(32)) dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .valid_in      (valid_in),
      .alu_op        (alu_op),
      .funct         (funct),
      .src_a         (src_a),
      .src_b         (src_b),
      .pc            (pc),
      .imm           (imm),
      .valid_out     (valid_out),
      .alu_ctrl      (alu_ctrl),
      .result        (result),
      .zero          (zero),
      .overflow      (overflow),
      .pc_plus4      (pc_plus4),
      .branch_target (branch_target)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [2:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc_v;
      logic [15:0] imm_v;
      logic [2:0]  e_ctrl;
      logic [31:0] e_res;
      logic        e_zero;
      logic        e_ovf;
      logic [31:0] e_pc4;
      logic [31:0] e_bt;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      check_cnt++;
      if (act !== exp_v) begin
         err_cnt++;
         $display("FAIL %s: got=%h want=%h", name, act, exp_v);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_valid, input logic [2:0] e_ctrl,
                          input logic [31:0] e_res, input logic e_zero, input logic e_ovf,
                          input logic [31:0] e_pc4, input logic [31:0] e_bt);
      chk({tag, ".valid_out"},     {31'b0, valid_out}, {31'b0, e_valid});
      chk({tag, ".alu_ctrl"},      {29'b0, alu_ctrl},  {29'b0, e_ctrl});
      chk({tag, ".result"},        result,             e_res);
      chk({tag, ".zero"},          {31'b0, zero},      {31'b0, e_zero});
      chk({tag, ".overflow"},      {31'b0, overflow},  {31'b0, e_ovf});
      chk({tag, ".pc_plus4"},      pc_plus4,           e_pc4);
      chk({tag, ".branch_target"}, branch_target,      e_bt);
   endtask

   task automatic drive(input vec_t v, input logic vld);
      valid_in = vld;
      alu_op   = v.op;
      funct    = v.fn;
      src_a    = v.a;
      src_b    = v.b;
      pc       = v.pc_v;
      imm      = v.imm_v;
   endtask

   initial begin
      //            op      fn     a             b             pc            imm       ctrl    result        z     o     pc4           bt
      vecs[0]  = '{3'b010, 6'h20, 32'd7,        32'd5,        32'h100,      16'h0003, 3'b010, 32'd12,       1'b0, 1'b0, 32'h104,      32'h110};
      vecs[1]  = '{3'b010, 6'h22, 32'd7,        32'd5,        32'h100,      16'h0003, 3'b110, 32'd2,        1'b0, 1'b0, 32'h104,      32'h110};
      vecs[2]  = '{3'b010, 6'h24, 32'd7,        32'd5,        32'h100,      16'h0003, 3'b000, 32'd5,        1'b0, 1'b0, 32'h104,      32'h110};
      vecs[3]  = '{3'b010, 6'h25, 32'd7,        32'd5,        32'h100,      16'h0003, 3'b001, 32'd7,        1'b0, 1'b0, 32'h104,      32'h110};
      vecs[4]  = '{3'b010, 6'h27, 32'd7,        32'd5,        32'h100,      16'h0003, 3'b100, 32'hFFFFFFF8, 1'b0, 1'b0, 32'h104,      32'h110};
      vecs[5]  = '{3'b010, 6'h2A, 32'd7,        32'd5,        32'h100,      16'h0003, 3'b111, 32'd0,        1'b1, 1'b0, 32'h104,      32'h110};
      vecs[6]  = '{3'b010, 6'h2A, 32'd5,        32'd7,        32'h100,      16'h0003, 3'b111, 32'd1,        1'b0, 1'b0, 32'h104,      32'h110};
      vecs[7]  = '{3'b001, 6'h00, 32'h1234,     32'h1234,     32'h200,      16'h0000, 3'b110, 32'd0,        1'b1, 1'b0, 32'h204,      32'h204};
      vecs[8]  = '{3'b001, 6'h00, 32'h1234,     32'h1235,     32'h200,      16'h0000, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h204,      32'h204};
      vecs[9]  = '{3'b000, 6'h00, 32'h7FFFFFFF, 32'h1,        32'h100,      16'h0003, 3'b010, 32'h80000000, 1'b0, 1'b1, 32'h104,      32'h110};
      vecs[10] = '{3'b001, 6'h00, 32'h80000000, 32'h1,        32'h100,      16'h0003, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h104,      32'h110};
      vecs[11] = '{3'b101, 6'h00, 32'hFFFFFFFF, 32'h1,        32'h100,      16'h0003, 3'b111, 32'd1,        1'b0, 1'b0, 32'h104,      32'h110};
      vecs[12] = '{3'b010, 6'h3F, 32'd3,        32'd4,        32'h100,      16'h0003, 3'b010, 32'd7,        1'b0, 1'b0, 32'h104,      32'h110};
      vecs[13] = '{3'b011, 6'h25, 32'hF0,       32'h3C,       32'h100,      16'h0003, 3'b000, 32'h30,       1'b0, 1'b0, 32'h104,      32'h110};
      vecs[14] = '{3'b100, 6'h24, 32'hF0,       32'h0F,       32'h100,      16'h0003, 3'b001, 32'hFF,       1'b0, 1'b0, 32'h104,      32'h110};
      vecs[15] = '{3'b110, 6'h22, 32'd1,        32'd1,        32'h100,      16'h0003, 3'b010, 32'd2,        1'b0, 1'b0, 32'h104,      32'h110};
      vecs[16] = '{3'b111, 6'h27, 32'd1,        32'd1,        32'h100,      16'h0003, 3'b010, 32'd2,        1'b0, 1'b0, 32'h104,      32'h110};
      vecs[17] = '{3'b000, 6'h00, 32'd0,        32'd0,        32'h100,      16'hFFFF, 3'b010, 32'd0,        1'b1, 1'b0, 32'h104,      32'h100};
      vecs[18] = '{3'b000, 6'h00, 32'd1,        32'd2,        32'hFFFFFFFC, 16'h0000, 3'b010, 32'd3,        1'b0, 1'b0, 32'h0,        32'h0};
      vecs[19] = '{3'b010, 6'h21, 32'hFFFFFFFF, 32'h1,        32'h100,      16'h0003, 3'b010, 32'd0,        1'b1, 1'b0, 32'h104,      32'h110};
      vecs[20] = '{3'b010, 6'h23, 32'd0,        32'd1,        32'h100,      16'h0003, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h104,      32'h110};
      vecs[21] = '{3'b000, 6'h00, 32'h80000000, 32'h80000000, 32'h100,      16'h0003, 3'b010, 32'd0,        1'b1, 1'b1, 32'h104,      32'h110};
      vecs[22] = '{3'b010, 6'h22, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFF0, 16'h8000, 3'b110, 32'h80000000, 1'b0, 1'b1, 32'h7FFFFFF4, 32'h7FFDFFF4};
      vecs[23] = '{3'b010, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 32'h1000,     16'h7FFF, 3'b111, 32'd1,        1'b0, 1'b0, 32'h1004,     32'h21000};

      // ---- Reset with valid_in=1 and nonzero inputs ----
      Rst_n = 1'b0;
      drive(vecs[0], 1'b1);
      repeat (2) @(posedge Clk);
      #1;
      $display("reset: valid_out=%0b result=%h", valid_out, result);
      chk_all("reset", 1'b0, 3'b000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

      // ---- Release: first valid sample appears one edge later ----
      Rst_n = 1'b1;
      @(posedge Clk);
      #1;
      $display("first: valid_out=%0b result=%h", valid_out, result);
      chk_all("first", 1'b1, vecs[0].e_ctrl, vecs[0].e_res, vecs[0].e_zero,
              vecs[0].e_ovf, vecs[0].e_pc4, vecs[0].e_bt);

      // ---- Table-driven vectors ----
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i], 1'b1);
         @(posedge Clk);
         #1;
         $display("vec %0d: op=%b fn=%h a=%h b=%h -> ctrl=%b res=%h z=%0b o=%0b pc4=%h bt=%h",
                  i, vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b,
                  alu_ctrl, result, zero, overflow, pc_plus4, branch_target);
         chk_all($sformatf("vec%0d", i), 1'b1, vecs[i].e_ctrl, vecs[i].e_res,
                 vecs[i].e_zero, vecs[i].e_ovf, vecs[i].e_pc4, vecs[i].e_bt);
      end

      // ---- Hold: load a known vector, then valid_in=0 with changing inputs ----
      drive(vecs[9], 1'b1);
      @(posedge Clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         drive(vecs[c + 1], 1'b0);
         @(posedge Clk);
         #1;
         $display("hold %0d: valid_out=%0b result=%h", c, valid_out, result);
         chk_all($sformatf("hold%0d", c), 1'b0, vecs[9].e_ctrl, vecs[9].e_res,
                 vecs[9].e_zero, vecs[9].e_ovf, vecs[9].e_pc4, vecs[9].e_bt);
      end

      // ---- Resume after hold ----
      drive(vecs[4], 1'b1);
      @(posedge Clk);
      #1;
      $display("resume: valid_out=%0b result=%h", valid_out, result);
      chk_all("resume", 1'b1, vecs[4].e_ctrl, vecs[4].e_res, vecs[4].e_zero,
              vecs[4].e_ovf, vecs[4].e_pc4, vecs[4].e_bt);

      // ---- Mid-run reset clears loaded outputs, even with valid_in=1 ----
      Rst_n = 1'b0;
      drive(vecs[22], 1'b1);
      @(posedge Clk);
      #1;
      $display("midreset: valid_out=%0b result=%h", valid_out, result);
      chk_all("midreset", 1'b0, 3'b000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

      Rst_n = 1'b1;
      @(posedge Clk);
      #1;
      $display("postreset: valid_out=%0b result=%h", valid_out, result);
      chk_all("postreset", 1'b1, vecs[22].e_ctrl, vecs[22].e_res, vecs[22].e_zero,
              vecs[22].e_ovf, vecs[22].e_pc4, vecs[22].e_bt);

      $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute-stage block for the single-cycle MIPS datapath.
- Merges three functions into one unit:
  - ALU control decode: alu_op plus funct → 3-bit ALU control.
  - 32-bit ALU with zero and overflow flags.
  - The two PC adders: PC+4, and branch target = PC+4 + (sign-extended immediate << 2).
- All results are captured in output registers one clock after the inputs are presented. Sits between the register file / control unit and the data memory / PC mux.

Parameters:
- WIDTH, 32, datapath width of operands, result, PC and adders.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous active-low reset.
- valid_in  input  1  inputs valid this cycle; outputs update only when high.
- alu_op  input  3  operation class from control unit.
- funct  input  6  instruction[5:0].
- src_a  input  32  ALU operand A (register read 1).
- src_b  input  32  ALU operand B (already muxed reg2/immediate).
- pc  input  32  current PC.
- imm  input  16  instruction[15:0].
- valid_out  output  1  registered copy of valid_in.
- alu_ctrl  output  3  registered decoded ALU control.
- result  output  32  registered ALU result.
- zero  output  1  registered (ALU result == 0).
- overflow  output  1  registered signed overflow for ADD/SUB.
- pc_plus4  output  32  registered pc + 4.
- branch_target  output  32  registered pc + 4 + (sext(imm) << 2).

Behaviour:
- Reset: on a rising Clk with Rst_n=0, all outputs become 0, including zero and valid_out. Reset dominates valid_in.
- Latency:
  - Outputs reflect inputs sampled at edge N, visible after edge N.
  - When valid_in=0 (and not in reset), all outputs hold their previous values, except valid_out, which goes to 0.
- ALU control decode (combinational, then registered):
  - alu_op 000 → ADD (010), used by lw/sw.
  - alu_op 001 → SUB (110), used by beq.
  - alu_op 011 → AND (000).
  - alu_op 100 → OR (001).
  - alu_op 101 → SLT (111).
  - alu_op 010 → decode funct:
    - 0x20 and 0x21 → ADD.
    - 0x22 and 0x23 → SUB.
    - 0x24 → AND.
    - 0x25 → OR.
    - 0x27 → NOR (100).
    - 0x2A → SLT.
    - Any other funct → ADD.
  - alu_op 110 and 111 → ADD.
- ALU operations:
  - AND: a & b.
  - OR: a | b.
  - NOR: ~(a | b).
  - ADD: a + b, modulo 2^32.
  - SUB: a − b, modulo 2^32.
  - SLT: signed compare; result = 32'h1 if $signed(a) < $signed(b), else 0.
  - Codes 011 and 101: result 0.
- Flags:
  - zero = (result == 0) for every operation.
  - overflow:
    - ADD: a and b have the same sign and the result sign differs.
    - SUB: a and b have different signs and the result sign differs from a.
    - All other operations: 0.
  - Overflow is a flag only; result is still written.
- PC adders:
  - pc_plus4 = pc + 4, wraps modulo 2^32 (0xFFFFFFFC → 0).
  - branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00}, wraps modulo 2^32.
  - Both are computed every valid cycle regardless of alu_op.
- No internal state other than the output registers. No combinational path from inputs to outputs.

Test Plan:
- Reset: Rst_n=0 for 2 cycles with valid_in=1 and nonzero inputs → all outputs 0. Release → first valid sample appears one cycle later.
- R-type: alu_op=010, src_a=7, src_b=5:
  - funct 0x20 → result=12, alu_ctrl=010.
  - funct 0x22 → result=2.
  - funct 0x24 → result=5.
  - funct 0x25 → result=7.
  - funct 0x27 → result=0xFFFFFFF8.
  - funct 0x2A → result=0.
  - Swapped operands with SLT → result=1.
- beq: alu_op=001, src_a=src_b=0x1234 → result=0, zero=1. With src_b=0x1235 → zero=0, result=0xFFFFFFFF.
- Overflow: ADD 0x7FFFFFFF + 1 → result=0x80000000, overflow=1. SUB 0x80000000 − 1 → result=0x7FFFFFFF, overflow=1. Signed SLT of 0xFFFFFFFF vs 1 → 1.
- PC adders:
  - pc=0x100, imm=0x0003 → pc_plus4=0x104, branch_target=0x110.
  - imm=0xFFFF → branch_target=0x100.
  - pc=0xFFFFFFFC → pc_plus4=0.
- Hold: valid_in=0 for 3 cycles with changing inputs → outputs unchanged and valid_out=0. Unknown funct 0x3F with alu_op=010 → ADD.
